prom_reader: RTL and testbench

Sequential read initiator for the 32×8 bipolar PROM parts (5610 family) in the CADR hardware model. On a start request it drives the PROM address and active-low chip enable and waits a programmable access time. It then captures each byte and streams it out over a valid/ready handshake with its address. It sits between a PROM part model and any consumer that needs the PROM image, such as a shadow RAM loader or a boot sequencer.

---
 rtl/prom_reader_pkg.sv | 16 +
 rtl/prom_reader_wait.sv | 31 +++
 rtl/prom_reader.sv | 145 ++++++++++++++
 tb/tb_prom_reader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/prom_reader_pkg.sv
// Shared types and default geometry for the 5610-family PROM sweep reader.
package prom_reader_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;
    localparam int PROM_DEPTH = 2 ** DEF_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_PRESENT,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/prom_reader_wait.sv
// prom_wait_timer: loadable down-counter with a zero flag; times the PROM access window.
module prom_wait_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/prom_reader.sv
// Sweeps every PROM location, waits the access time, and streams bytes out over valid/ready.
// Optional running checksum is built only when PROM_READER_CHECKSUM_EN is defined.
module prom_reader
    import prom_reader_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] prom_a,
    output logic              prom_ce_n,
    input  logic [DATA_W-1:0] prom_d,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              ce_n_q, ce_n_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tmr_load, tmr_dec, tmr_zero;

    prom_wait_timer #(.CNT_W(CNT_W)) u_wait (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (WAIT_LOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = '0;
                    tmr_load = 1'b1;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (tmr_zero) state_d = ST_CAPTURE;
                else          tmr_dec = 1'b1;
            end
            ST_CAPTURE: begin
                out_data_d = prom_d;
                out_addr_d = addr_q;
                state_d    = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_FINISH;
                    end else begin
                        addr_d   = addr_q + 1'b1;
                        tmr_load = 1'b1;
                        state_d  = ST_ACCESS;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        ce_n_d  = !((state_d == ST_ACCESS) || (state_d == ST_CAPTURE));
        valid_d = (state_d == ST_PRESENT);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
            ce_n_q     <= 1'b1;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            out_data_q <= out_data_d;
            out_addr_q <= out_addr_d;
            ce_n_q     <= ce_n_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef PROM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if ((state_q == ST_IDLE) && start) sum_d = '0;
        else if (state_q == ST_CAPTURE)    sum_d = sum_q + prom_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sum_q <= '0;
        else          sum_q <= sum_d;
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign prom_a    = addr_q;
    assign prom_ce_n = ce_n_q;
    assign out_valid = valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_prom_reader.sv
// Directed bench for prom_reader: PROM model, scoreboard of expected (addr,data) pairs.
module tb_prom_reader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b1;
    logic [4:0] prom_a;
    logic       prom_ce_n;
    logic [7:0] prom_d;
    logic       out_valid;
    logic [7:0] out_data;
    logic [4:0] out_addr;
    logic       busy;
    logic       done;
    logic [7:0] checksum;

    logic [7:0]  mem [32];
    logic [12:0] sbq [$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign prom_d = prom_ce_n ? 8'hxx : mem[prom_a];

    prom_reader #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .prom_a    (prom_a),
        .prom_ce_n (prom_ce_n),
        .prom_d    (prom_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_sum(input logic [7:0] s);
`ifdef PROM_READER_CHECKSUM_EN
        return s;
`else
        return (s & 8'h00);
`endif
    endfunction

    // Runs one sweep from a start pulse; optional stall, mid-sweep restart and reset points.
    task automatic sweep(input int stall_addr, input int restart_addr, input int reset_addr,
                         output int done_cyc, output int ndone);
        logic [12:0] e;
        logic [7:0]  sum = 8'h00;
        int stall_left = 5;
        int cyc = 1;
        int post = 0;
        bit restarted = 1'b0;
        bit stalling;
        done_cyc = 0;
        ndone = 0;
        for (int i = 0; i < 32; i++) begin
            sbq.push_back({5'(i), mem[i]});
            sum += mem[i];
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 600 && post < 12) begin
            if (done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = cyc;
                check("checksum_at_done", 32'(checksum), 32'(exp_sum(sum)));
            end
            if (done_cyc != 0) post++;
            out_ready = 1'b1;
            start = 1'b0;
            stalling = (stall_left > 0) &&
                       ((stall_left < 5) || (out_valid && int'(out_addr) == stall_addr));
            if (stalling) begin
                out_ready = 1'b0;
                stall_left--;
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(mem[stall_addr]));
                check("stall_ce_n", 32'(prom_ce_n), 32'd1);
            end
            if (out_valid && int'(out_addr) == restart_addr && !restarted) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (out_valid && int'(out_addr) == reset_addr) begin
                reset_n = 1'b0;
                #1;
                check("rst_ce_n", 32'(prom_ce_n), 32'd1);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_valid", 32'(out_valid), 32'd0);
                check("rst_checksum", 32'(checksum), 32'd0);
                repeat (3) begin
                    @(negedge clk);
                    check("rst_no_done", 32'(done), 32'd0);
                end
                reset_n = 1'b1;
                sbq.delete();
                repeat (4) begin
                    @(negedge clk);
                    check("post_rst_idle", 32'(busy), 32'd0);
                    check("post_rst_no_done", 32'(done), 32'd0);
                end
                return;
            end
            if (out_valid && out_ready) begin
                tests++;
                assert (sbq.size() != 0) else begin
                    fails++;
                    $error("FAIL sb_underflow: observed addr %0d expected none", out_addr);
                end
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("hs_addr", 32'(out_addr), 32'(e[12:8]));
                    check("hs_data", 32'(out_data), 32'(e[7:0]));
                end
            end
            @(negedge clk);
            cyc++;
        end
        tests++;
        assert (cyc < 600) else begin
            fails++;
            $error("FAIL sweep_timeout: observed %0d cycles expected done", cyc);
        end
        check("sb_drained", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    initial begin
        int dc, nd;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i) ^ 8'hA5;

        // Reset held with start asserted: nothing must move.
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ce_n", 32'(prom_ce_n), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_addr", 32'(out_addr), 32'd0);
        check("reset_prom_a", 32'(prom_a), 32'd0);
        check("reset_checksum", 32'(checksum), 32'd0);
        start = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", 32'(busy), 32'd0);
        check("idle_ce_n", 32'(prom_ce_n), 32'd1);

        // Clean sweep, ready held high.
        sweep(-1, -1, -1, dc, nd);
        check("done_cycle", 32'(dc), 32'd129);
        check("done_count", 32'(nd), 32'd1);
        check("idle_after_sweep", 32'(busy), 32'd0);

        // Stall at address 7 for 5 cycles, stray start at address 12.
        sweep(7, 12, -1, dc, nd);
        check("stall_done_cycle", 32'(dc), 32'd134);
        check("stall_done_count", 32'(nd), 32'd1);

        // Reset mid-sweep at address 20, then a fresh sweep from 0.
        sweep(-1, -1, 20, dc, nd);
        check("reset_sweep_no_done", 32'(nd), 32'd0);
        sweep(-1, -1, -1, dc, nd);
        check("resweep_done_cycle", 32'(dc), 32'd129);
        check("resweep_done_count", 32'(nd), 32'd1);

        // Flat image of 0x01: checksum 0x20 when accumulated, 0 otherwise.
        for (int i = 0; i < 32; i++) mem[i] = 8'h01;
        sweep(-1, -1, -1, dc, nd);
        check("flat_done_count", 32'(nd), 32'd1);
`ifdef PROM_READER_CHECKSUM_EN
        check("flat_checksum", 32'(checksum), 32'h20);
`else
        check("flat_checksum", 32'(checksum), 32'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
